// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement controller.
// Ring-code pattern, FSM state encoding and the ring-code legality check.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DECODE,
        RESULT
    } state_t;

    localparam int TAP_N  = 32;
    localparam int FINE_W = 5;

    localparam logic [TAP_N-1:0] RING_PAT0 = 32'h0000_FFFF;

    // Base ring pattern rotated right by k taps
    function automatic logic [TAP_N-1:0] ror_pat(input int k);
        return (RING_PAT0 >> k) | (RING_PAT0 << (TAP_N - k));
    endfunction

    // True when the snapshot is one of the 32 rotations of the base pattern
    function automatic logic ring_code_ok(input logic [TAP_N-1:0] snap);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < TAP_N; k++) begin
            if (snap == ror_pat(k)) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tdc_meas_ctrl_decode.sv
// 32-tap ring snapshot to 5-bit fine code.
// The fine code is the rotation index; non-ring codes decode to 0.
module tdc_meas_ctrl_decode
    import tdc_pkg::*;
(
    input  logic [TAP_N-1:0]  snap,
    output logic [FINE_W-1:0] fine
);

    // Match the snapshot against every legal rotation
    always_comb begin
        fine = '0;
        for (int k = 0; k < TAP_N; k++) begin
            if (snap == ror_pat(k)) fine = FINE_W'(k);
        end
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arm, wait for hit, capture, decode, present result.
// Optional macro TDC_ERR_CNT_EN adds a saturating illegal-code counter (err_cnt).
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int CW          = 11,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit AUTO_REARM  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              hit,
    input  logic [TAP_N-1:0]  tap_snap,
    output logic [CW+4:0]     ts_data,
    output logic              ts_err,
    output logic              ts_timeout,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic              busy,
    output logic              hit_miss
`ifdef TDC_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [CW-1:0]      coarse;
    logic [CW-1:0]      coarse_q;
    logic [TAP_N-1:0]   snap_q;
    logic [FINE_W-1:0]  fine;
    logic               code_ok;

    tdc_meas_ctrl_decode u_decode (
        .snap (snap_q),
        .fine (fine)
    );

    assign code_ok = ring_code_ok(snap_q);
    assign busy    = (state != IDLE);

    // Measurement FSM with coarse counter, capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            coarse     <= '0;
            coarse_q   <= '0;
            snap_q     <= '0;
            ts_data    <= '0;
            ts_err     <= 1'b0;
            ts_timeout <= 1'b0;
            ts_valid   <= 1'b0;
            hit_miss   <= 1'b0;
        end else begin
            hit_miss <= hit && (state != ARMED);
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        state  <= ARMED;
                        coarse <= '0;
                    end
                end
                ARMED: begin
                    coarse <= coarse + CW'(1);
                    if (hit) begin
                        snap_q   <= tap_snap;
                        coarse_q <= coarse;
                        state    <= DECODE;
                    end else if (coarse == TO_LAST) begin
                        ts_data    <= '1;
                        ts_err     <= 1'b0;
                        ts_timeout <= 1'b1;
                        ts_valid   <= 1'b1;
                        state      <= RESULT;
                    end
                end
                DECODE: begin
                    ts_data    <= {coarse_q, code_ok ? fine : {FINE_W{1'b0}}};
                    ts_err     <= !code_ok;
                    ts_timeout <= 1'b0;
                    ts_valid   <= 1'b1;
                    state      <= RESULT;
                end
                RESULT: begin
                    if (ts_ready) begin
                        ts_valid   <= 1'b0;
                        ts_err     <= 1'b0;
                        ts_timeout <= 1'b0;
                        if (AUTO_REARM) begin
                            state  <= ARMED;
                            coarse <= '0;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef TDC_ERR_CNT_EN
    // Count illegal snapshots, saturating at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (state == DECODE && !code_ok && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: main instance plus an auto-rearm instance.
// Expected results are queued at stimulus time and checked by per-DUT monitors.
module tb_tdc_meas_ctrl;

    localparam int CW = 11;
    localparam int TO = 16;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        arm = 1'b0, hit = 1'b0, ts_ready = 1'b1;
    logic [31:0] tap_snap = '0;
    logic [15:0] ts_data;
    logic        ts_err, ts_timeout, ts_valid, busy, hit_miss;

    logic        arm2 = 1'b0, hit2 = 1'b0, ready2 = 1'b1;
    logic [31:0] tap2 = '0;
    logic [15:0] data2;
    logic        err2, tmo2, valid2, busy2, miss2;

`ifdef TDC_ERR_CNT_EN
    logic [7:0]  err_cnt, err_cnt2;
`endif

    tdc_meas_ctrl #(.CW(CW), .TIMEOUT_CYC(TO), .AUTO_REARM(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .hit        (hit),
        .tap_snap   (tap_snap),
        .ts_data    (ts_data),
        .ts_err     (ts_err),
        .ts_timeout (ts_timeout),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .busy       (busy),
        .hit_miss   (hit_miss)
`ifdef TDC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    tdc_meas_ctrl #(.CW(CW), .TIMEOUT_CYC(TO), .AUTO_REARM(1'b1)) u_ar (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm2),
        .hit        (hit2),
        .tap_snap   (tap2),
        .ts_data    (data2),
        .ts_err     (err2),
        .ts_timeout (tmo2),
        .ts_valid   (valid2),
        .ts_ready   (ready2),
        .busy       (busy2),
        .hit_miss   (miss2)
`ifdef TDC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance
    logic pv1 = 1'b0;
    int   vs1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv1 = 1'b0;
        end else begin
            if (ts_valid && !pv1) vs1 = cyc;
            pv1 = ts_valid;
            if (!ts_valid) chk("qual1", {30'd0, ts_err, ts_timeout}, 32'd0);
            if (ts_valid && ts_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexp1: got result %h with empty queue", ts_data);
                end else begin
                    e = q1.pop_front();
                    chk("data1", ts_data, e.data);
                    chk("err1", ts_err, e.err);
                    chk("tmo1", ts_timeout, e.tmo);
                    chk("lat1", vs1, e.cyc);
                end
            end
        end
    end

    // Monitor for the auto-rearm instance
    logic pv2 = 1'b0;
    int   vs2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv2 = 1'b0;
        end else begin
            if (valid2 && !pv2) vs2 = cyc;
            pv2 = valid2;
            if (valid2 && ready2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexp2: got result %h with empty queue", data2);
                end else begin
                    e = q2.pop_front();
                    chk("data2", data2, e.data);
                    chk("err2", err2, e.err);
                    chk("tmo2", tmo2, e.tmo);
                    chk("lat2", vs2, e.cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || ts_valid) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (busy || ts_valid) begin
            errors++;
            $display("FAIL idle_wait: busy %0b valid %0b required 0 0", busy, ts_valid);
        end
    endtask

    // Arm, hit d cycles after the arm cycle, expect result two cycles later
    task automatic measure(input int d, input logic [31:0] tap,
                           input logic [15:0] exp_data, input logic exp_err);
        int a;
        a = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (d - 1) tick();
        hit = 1'b1;
        tap_snap = tap;
        q1.push_back('{exp_data, exp_err, 1'b0, a + d + 2});
        tick();
        hit = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        repeat (3) tick();
        chk("rst_data", ts_data, 16'h0000);
        chk("rst_flags", {ts_err, ts_timeout, ts_valid, busy, hit_miss}, 5'b0);
`ifdef TDC_ERR_CNT_EN
        chk("rst_ecnt", err_cnt, 8'h00);
`endif
        rst = 1'b0;
        tick();

        // Basic capture, several ring codes, hit in the timeout cycle
        measure(3, 32'hF000_0FFF, 16'h0044, 1'b0);
        measure(4, 32'h0000_FFFF, 16'h0060, 1'b0);
        measure(5, 32'h0001_FFFE, 16'h009F, 1'b0);
        measure(16, 32'hFFFF_0000, 16'h01F0, 1'b0);

        // Timeout with no hit
        a = cyc;
        arm = 1'b1;
        q1.push_back('{16'hFFFF, 1'b0, 1'b1, a + 17});
        tick();
        arm = 1'b0;
        wait_idle();

        // Illegal snapshot
`ifdef TDC_ERR_CNT_EN
        chk("ecnt0", err_cnt, 8'h00);
`endif
        measure(2, 32'h0000_FFFE, 16'h0020, 1'b1);
`ifdef TDC_ERR_CNT_EN
        chk("ecnt1", err_cnt, 8'h01);
        for (int i = 0; i < 300; i++) measure(2, 32'h0000_FFFE, 16'h0020, 1'b1);
        chk("ecnt_sat", err_cnt, 8'hFF);
`endif

        // Hit while idle
        hit = 1'b1;
        tap_snap = 32'h1234_5678;
        tick();
        hit = 1'b0;
        chk("miss_idle", {hit_miss, busy, ts_valid}, 3'b100);
        tick();
        chk("miss_idle_end", hit_miss, 1'b0);

        // Backpressure with stray hit and arm during RESULT
        ts_ready = 1'b0;
        a = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        hit = 1'b1;
        tap_snap = 32'hFF00_00FF;
        q1.push_back('{16'h0028, 1'b0, 1'b0, a + 4});
        tick();
        hit = 1'b0;
        tick();
        chk("hold_a4", {ts_valid, ts_data}, {1'b1, 16'h0028});
        tick();
        hit = 1'b1;
        tap_snap = 32'hDEAD_BEEF;
        chk("hold_a5", {ts_valid, ts_data}, {1'b1, 16'h0028});
        tick();
        hit = 1'b0;
        arm = 1'b1;
        chk("miss_res", hit_miss, 1'b1);
        chk("hold_a6", {ts_valid, ts_data}, {1'b1, 16'h0028});
        tick();
        arm = 1'b0;
        chk("miss_res_end", hit_miss, 1'b0);
        chk("hold_a7", {ts_valid, ts_data}, {1'b1, 16'h0028});
        tick();
        chk("hold_a8", {ts_valid, ts_data, ts_err}, {1'b1, 16'h0028, 1'b0});
        ts_ready = 1'b1;
        tick();
        tick();
        chk("accept_idle", {busy, ts_valid}, 2'b00);
        ts_ready = 1'b1;

        // Reset while armed
        a = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_data", ts_data, 16'h0000);
        chk("rst_mid_flags", {ts_err, ts_timeout, ts_valid, busy, hit_miss}, 5'b0);
        tick();
        rst = 1'b0;
        tick();
        measure(4, 32'h0000_FFFF, 16'h0060, 1'b0);

        // Auto-rearm instance
        a = cyc;
        arm2 = 1'b1;
        tick();
        arm2 = 1'b0;
        tick();
        hit2 = 1'b1;
        tap2 = 32'h8000_7FFF;
        q2.push_back('{16'h0021, 1'b0, 1'b0, a + 4});
        tick();
        hit2 = 1'b0;
        tick();
        tick();
        chk("ar_busy", {busy2, valid2}, 2'b10);
        hit2 = 1'b1;
        tap2 = 32'hC000_3FFF;
        q2.push_back('{16'h0002, 1'b0, 1'b0, a + 7});
        tick();
        hit2 = 1'b0;
        q2.push_back('{16'hFFFF, 1'b0, 1'b1, a + 24});
        for (int n = 0; n < 60 && q2.size() > 0; n++) tick();
        ready2 = 1'b0;
        chk("q2_empty", q2.size(), 32'd0);
        chk("ar_busy_after", busy2, 1'b1);

        chk("q1_empty", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
